// File: rtl/adcfifo_pkg.sv
// Shared types and helpers for the ADC sample FIFO (64 x 16, two-port RAM).
// Used by both the read-side and the write-side controllers.
package adcfifo_pkg;

    localparam int ADCFIFO_DW = 16;
    localparam int ADCFIFO_AW = 6;

    // Pointers carry one extra wrap bit above the RAM address.
    typedef logic [ADCFIFO_AW:0]   ptr_t;
    typedef logic [ADCFIFO_DW-1:0] sample_t;

    // Number of entries between two pointers, modulo 2^(AW+1).
    function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/adcfifo_skid2.sv
// Two-entry register FIFO that absorbs the RAM read latency on the read side.
// Supports simultaneous push and pop (order preserved) and a synchronous clear.
module adcfifo_skid2
    import adcfifo_pkg::*;
#(
    parameter int DW = ADCFIFO_DW
)
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_count;
    logic          w_pop;

    // A pop on an empty buffer is ignored.
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_dout  = r_head;
    assign o_count = r_count;

    // Entry storage and occupancy; clear wins over push/pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_din;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_din;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/adcfifo_rd_ctrl.sv
// Read-side controller of the ADC sample FIFO: issues RAM reads while the RAM
// holds unread samples, absorbs the one-cycle read latency in a 2-entry skid
// buffer and streams samples out on a valid/ready interface.
// Optional feature macro: ADCFIFO_RD_WATERMARK_EN (adds wm_thresh / wm_hit).
//
// Handshake: a sample transfers on every rising CLK edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and out_data
// holds steady while out_valid is high and out_ready is low.
module adcfifo_rd_ctrl
    import adcfifo_pkg::*;
#(
    parameter int DW = ADCFIFO_DW,
    parameter int AW = ADCFIFO_AW
)
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW:0]   wr_ptr,
    output logic [AW:0]   rd_ptr,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_ren,
    input  logic [DW-1:0] ram_rd,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic          flush
`ifdef ADCFIFO_RD_WATERMARK_EN
    ,
    input  logic [AW:0]   wm_thresh,
    output logic          wm_hit
`endif
);

    logic [AW:0] r_rd_ptr;
    logic        r_rd_inflight;
    logic [1:0]  w_count;
    logic        w_ram_empty;
    logic        w_pop;
    logic        w_issue;
    logic [2:0]  w_occ;
    logic [2:0]  w_occ_after;

    // Full-width compare: RAM-full (pointers differ only in the wrap bit) is non-empty.
    assign w_ram_empty = (wr_ptr == r_rd_ptr);
    assign w_pop       = out_valid && out_ready;

    // Buffered plus in-flight samples, less the one leaving this cycle. Counting
    // the departing sample lets a new read issue every cycle while streaming.
    assign w_occ       = {1'b0, w_count} + {2'b00, r_rd_inflight};
    assign w_occ_after = w_occ - {2'b00, w_pop};
    assign w_issue     = !flush && !w_ram_empty && (w_occ_after < 3'd2);

    assign ram_ren   = w_issue;
    assign ram_raddr = r_rd_ptr[AW-1:0];
    assign rd_ptr    = r_rd_ptr;
    assign out_valid = (w_count != 2'd0);
    assign level     = ptr_diff(wr_ptr, r_rd_ptr);
    assign empty     = w_ram_empty && (w_count == 2'd0) && !r_rd_inflight;

    // Read pointer advance and read-latency tracking; flush resyncs to the writer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr      <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (flush) begin
                r_rd_ptr <= wr_ptr;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_inflight <= w_issue;
        end
    end

    adcfifo_skid2 #(.DW(DW)) u_skid (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_push  (r_rd_inflight),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_din   (ram_rd),
        .o_dout  (out_data),
        .o_count (w_count)
    );

`ifdef ADCFIFO_RD_WATERMARK_EN
    logic r_wm_hit;
    assign wm_hit = r_wm_hit;

    // Registered watermark flag; a zero threshold always reports a hit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wm_hit <= 1'b0;
        end else begin
            r_wm_hit <= (wm_thresh == '0) || (level >= wm_thresh);
        end
    end
`endif

endmodule

// File: tb/tb_adcfifo_rd_ctrl.sv
// Testbench for adcfifo_rd_ctrl: a writer/RAM model feeds the controller,
// expected samples are queued when written and a monitor pops and compares
// them on every out_valid & out_ready handshake.
module tb_adcfifo_rd_ctrl;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk;
    logic          RESET;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] ram_raddr;
    logic          ram_ren;
    logic [DW-1:0] ram_rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          empty;
    logic [AW:0]   level;
    logic          flush;
`ifdef ADCFIFO_RD_WATERMARK_EN
    logic [AW:0]   wm_thresh;
    logic          wm_hit;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            n_checks;
    int            n_errors;
    int            rx_count;
    int            ready_mode;
    int            rx0;

    adcfifo_rd_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK       (clk),
        .RESET     (RESET),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .ram_raddr (ram_raddr),
        .ram_ren   (ram_ren),
        .ram_rd    (ram_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .empty     (empty),
        .level     (level),
        .flush     (flush)
`ifdef ADCFIFO_RD_WATERMARK_EN
        ,
        .wm_thresh (wm_thresh),
        .wm_hit    (wm_hit)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_ren) ram_rd <= mem[ram_raddr];
    end

    // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = toggling
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        flush      = 1'b0;
        wr_ptr     = '0;
        ready_mode = 0;
        exp_q.delete();
        repeat (2) tick();
        RESET = 1'b0;
        tick();
    endtask

    // Writer model: fill n RAM slots from wr_ptr, queue them, then bump wr_ptr once.
    task automatic preload(input int n, input logic [DW-1:0] base);
        logic [AW:0] p;
        p = wr_ptr;
        for (int i = 0; i < n; i++) begin
            mem[p[AW-1:0]] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            p = p + 1'b1;
        end
        wr_ptr = p;
    endtask

    task automatic wait_drain(input int bound, input string name);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!RESET && out_valid && out_ready) begin
                rx_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sample_unexpected: got 0x%0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_errors++;
                        $display("FAIL sample_data: got 0x%0h expected 0x%0h", out_data, e);
                    end
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rx_count = 0;
        ready_mode = 0;
        ram_rd = '0;
`ifdef ADCFIFO_RD_WATERMARK_EN
        wm_thresh = 7'd4;
`endif
        do_reset();

        // 1: idle after reset
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_empty", 32'(empty), 32'd1);
            check("idle_ren", 32'(ram_ren), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_rd_ptr", 32'(rd_ptr), 32'd0);
            tick();
        end
        check("idle_level", 32'(level), 32'd0);
        check("idle_out_data", 32'(out_data), 32'd0);

        // 2: stream 10 samples, latency and back-to-back delivery
        ready_mode = 1;
        tick();
        tick();
        preload(10, 16'h0000);
        @(negedge clk);
        check("lat_valid_n0", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid_n1", 32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        tick();
        @(negedge clk);
        check("stream_done_valid", 32'(out_valid), 32'd0);
        check("stream_rd_ptr", 32'(rd_ptr), 32'd10);
        check("stream_empty", 32'(empty), 32'd1);
        check("stream_queue", 32'(exp_q.size()), 32'd0);

        // 3: backpressure, then toggling ready
        do_reset();
        preload(10, 16'h0100);
        repeat (20) tick();
        @(negedge clk);
        check("stall_rd_ptr", 32'(rd_ptr), 32'd2);
        check("stall_level", 32'(level), 32'd8);
        check("stall_ren", 32'(ram_ren), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", 32'(out_data), 32'h0100);
        rx0 = rx_count;
        ready_mode = 2;
        wait_drain(100, "stall_drain");
        check("stall_rx_count", 32'(rx_count - rx0), 32'd10);
        tick();
        @(negedge clk);
        check("stall_end_rd_ptr", 32'(rd_ptr), 32'd10);
        check("stall_end_empty", 32'(empty), 32'd1);

        // 4: wrap-around from pointer 60
        do_reset();
        ready_mode = 1;
        wr_ptr = 7'd60;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("wrap_start_rd_ptr", 32'(rd_ptr), 32'd60);
        check("wrap_start_empty", 32'(empty), 32'd1);
        tick();
        preload(8, 16'h0400);
        @(negedge clk);
        check("wrap_level", 32'(level), 32'd8);
        wait_drain(50, "wrap_drain");
        tick();
        @(negedge clk);
        check("wrap_rd_ptr", 32'(rd_ptr), 32'd68);
        check("wrap_level_end", 32'(level), 32'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        // 5: RAM full, drain 64 samples
        do_reset();
        preload(64, 16'h0500);
        @(negedge clk);
        check("full_level", 32'(level), 32'd64);
        check("full_empty", 32'(empty), 32'd0);
        check("full_ren", 32'(ram_ren), 32'd1);
        rx0 = rx_count;
        tick();
        ready_mode = 1;
        wait_drain(200, "full_drain");
        check("full_rx_count", 32'(rx_count - rx0), 32'd64);
        tick();
        @(negedge clk);
        check("full_rd_ptr", 32'(rd_ptr), 32'd64);
        check("full_end_empty", 32'(empty), 32'd1);

        // 6: flush while streaming with a read in flight
        do_reset();
        ready_mode = 1;
        tick();
        tick();
        preload(20, 16'h0600);
        rx0 = rx_count;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_rx_count", 32'(rx_count - rx0), 32'd4);
        exp_q.delete();
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rd_ptr", 32'(rd_ptr), 32'd20);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_level", 32'(level), 32'd0);
        tick();
        @(negedge clk);
        check("flush_after_ren", 32'(ram_ren), 32'd0);
        check("flush_after_valid", 32'(out_valid), 32'd0);

`ifdef ADCFIFO_RD_WATERMARK_EN
        // watermark at threshold 4
        wm_thresh = 7'd4;
        do_reset();
        @(negedge clk);
        check("wm_reset", 32'(wm_hit), 32'd0);
        tick();
        preload(3, 16'h0700);
        @(negedge clk);
        check("wm_low_a", 32'(wm_hit), 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("wm_low_b", 32'(wm_hit), 32'd0);
        tick();
        preload(5, 16'h0703);
        @(negedge clk);
        check("wm_level6", 32'(level), 32'd6);
        check("wm_pre_hit", 32'(wm_hit), 32'd0);
        tick();
        @(negedge clk);
        check("wm_hit_on", 32'(wm_hit), 32'd1);
        ready_mode = 1;
        wait_drain(50, "wm_drain");
        tick();
        tick();
        @(negedge clk);
        check("wm_hit_off", 32'(wm_hit), 32'd0);
        tick();
        wm_thresh = '0;
        @(negedge clk);
        check("wm_zero_pre", 32'(wm_hit), 32'd0);
        tick();
        @(negedge clk);
        check("wm_zero_hit", 32'(wm_hit), 32'd1);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
